// File: rtl/sdram_byte_port_if.sv
// Client byte ports and SDRAM-controller channel of sdram_byte_port.
// The slave modport is the adapter's view; the master modport is the client/controller side.
interface sdram_byte_port_if #(
  parameter int ADDR_BITS = 23
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [7:0]           wr_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [7:0]           rd_data;
  logic                 rd_done;
  logic                 mem_req;
  logic                 mem_ack;
  logic                 mem_we;
  logic [1:0]           mem_wm;
  logic [ADDR_BITS-2:0] mem_address;
  logic [15:0]          mem_data_write;
  logic [15:0]          mem_data_read;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_ack, mem_data_read,
    output wr_ready, rd_ready, rd_data, rd_done, mem_req, mem_we, mem_wm, mem_address,
           mem_data_write
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_ack, mem_data_read,
    input  wr_ready, rd_ready, rd_data, rd_done, mem_req, mem_we, mem_wm, mem_address,
           mem_data_write
  );
endinterface

// File: rtl/sdram_byte_port.sv
// Byte-wide client adapter onto one toggle req/ack SDRAM controller channel.
// Byte writes are queued in a small FIFO; single-byte reads are ordered behind them.
module sdram_byte_port #(
  parameter int ADDR_BITS = 23,
  parameter int DEPTH     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  sdram_byte_port_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int WA_W  = ADDR_BITS - 1;

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_READ  = 2'd3;

  logic [1:0]           state_r;
  logic [1:0]           state_s;
  logic [WA_W-1:0]      fifo_addr_r [DEPTH];
  logic                 fifo_lane_r [DEPTH];
  logic [7:0]           fifo_data_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [PTR_W-1:0]     count_s;
  logic [IDX_W-1:0]     head_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 issue_rd_s;
  logic                 ack_match_s;
  logic                 rd_complete_s;
  logic                 read_pending_r;
  logic [ADDR_BITS-1:0] rd_addr_r;
  logic                 mem_req_r;
  logic                 mem_we_r;
  logic [1:0]           mem_wm_r;
  logic [WA_W-1:0]      mem_address_r;
  logic [15:0]          mem_data_write_r;
  logic [7:0]           rd_data_r;
  logic                 rd_done_r;

  // Queue status, issue decisions and next-state selection
  always_comb begin
    count_s       = wr_ptr_r - rd_ptr_r;
    full_s        = (count_s == PTR_W'(DEPTH));
    empty_s       = (count_s == {PTR_W{1'b0}});
    head_s        = rd_ptr_r[IDX_W-1:0];
    ack_match_s   = (bus.mem_ack == mem_req_r);
    push_s        = bus.wr_valid & ~full_s;
    pop_s         = (state_r == ST_IDLE) & ~empty_s;
    issue_rd_s    = (state_r == ST_IDLE) & empty_s & read_pending_r;
    rd_complete_s = (state_r == ST_READ) & ack_match_s;
    state_s       = state_r;
    case (state_r)
      ST_SYNC: begin
        if (ack_match_s) state_s = ST_IDLE;
        else             state_s = ST_SYNC;
      end
      ST_IDLE: begin
        if (pop_s)           state_s = ST_WRITE;
        else if (issue_rd_s) state_s = ST_READ;
        else                 state_s = ST_IDLE;
      end
      ST_WRITE, ST_READ: begin
        if (ack_match_s) state_s = ST_IDLE;
        else             state_s = state_r;
      end
      default: state_s = ST_SYNC;
    endcase
  end

  // Write FIFO storage and wrapping pointers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_r[i] <= {WA_W{1'b0}};
        fifo_lane_r[i] <= 1'b0;
        fifo_data_r[i] <= 8'h00;
      end
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r[IDX_W-1:0]] <= bus.wr_addr[ADDR_BITS-1:1];
        fifo_lane_r[wr_ptr_r[IDX_W-1:0]] <= bus.wr_addr[0];
        fifo_data_r[wr_ptr_r[IDX_W-1:0]] <= bus.wr_data;
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // State register, read holding register and read result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_SYNC;
      read_pending_r <= 1'b0;
      rd_addr_r      <= {ADDR_BITS{1'b0}};
      rd_data_r      <= 8'h00;
      rd_done_r      <= 1'b0;
    end else begin
      state_r   <= state_s;
      rd_done_r <= rd_complete_s;
      if (rd_complete_s) begin
        rd_data_r      <= rd_addr_r[0] ? bus.mem_data_read[15:8] : bus.mem_data_read[7:0];
        read_pending_r <= 1'b0;
      end else if (bus.rd_valid && !read_pending_r) begin
        read_pending_r <= 1'b1;
        rd_addr_r      <= bus.rd_addr;
      end
    end
  end

  // Controller channel: mem_* only change on the cycle that toggles mem_req
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_r        <= 1'b0;
      mem_we_r         <= 1'b0;
      mem_wm_r         <= 2'b11;
      mem_address_r    <= {WA_W{1'b0}};
      mem_data_write_r <= 16'h0000;
    end else if (pop_s) begin
      mem_req_r        <= ~mem_req_r;
      mem_we_r         <= 1'b1;
      mem_address_r    <= fifo_addr_r[head_s];
      mem_wm_r         <= fifo_lane_r[head_s] ? 2'b01 : 2'b10;
      mem_data_write_r <= fifo_lane_r[head_s] ? {fifo_data_r[head_s], 8'h00}
                                              : {8'h00, fifo_data_r[head_s]};
    end else if (issue_rd_s) begin
      mem_req_r     <= ~mem_req_r;
      mem_we_r      <= 1'b0;
      mem_wm_r      <= 2'b00;
      mem_address_r <= rd_addr_r[ADDR_BITS-1:1];
    end else begin
      mem_req_r <= mem_req_r;
    end
  end

  assign bus.wr_ready       = ~full_s;
  assign bus.rd_ready       = ~read_pending_r;
  assign bus.rd_data        = rd_data_r;
  assign bus.rd_done        = rd_done_r;
  assign bus.mem_req        = mem_req_r;
  assign bus.mem_we         = mem_we_r;
  assign bus.mem_wm         = mem_wm_r;
  assign bus.mem_address    = mem_address_r;
  assign bus.mem_data_write = mem_data_write_r;
endmodule
